// File: rtl/mdio_slave.sv
// mdio_slave: Clause-22 MDIO target with synchronized MDC/MDIO and a register strobe interface.
module mdio_slave #(
    parameter int PRE_LEN = 32
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic [4:0]  phy_addr_i,
    output logic [4:0]  reg_addr_o,
    output logic [15:0] reg_wdata_o,
    output logic        reg_wr_o,
    output logic        reg_rd_o,
    input  logic [15:0] reg_rdata_i
);
    localparam int CW = $clog2(PRE_LEN + 1);

    typedef enum logic [2:0] {IDLE, ST, OP, PHYAD, REGAD, TA, DATA} state_t;

    state_t        state_q, state_d;
    logic [1:0]    mdc_s_q, mdio_s_q;
    logic          mdc_p_q;
    logic [CW-1:0] pre_q, pre_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          op_q, op_d, rd_q, rd_d, sel_q, sel_d;
    logic [4:0]    adr_q, adr_d;
    logic [15:0]   sh_q, sh_d;
    logic          oe_q, oe_d, dout_q, dout_d, wr_q, wr_d, rdp_q, rdp_d;
    logic [4:0]    raddr_q, raddr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          re, din, pre_full;

    assign re        = mdc_s_q[1] & ~mdc_p_q;
    assign din       = mdio_s_q[1];
    assign pre_full  = pre_q == CW'(PRE_LEN);
    assign mdio_o      = dout_q;
    assign mdio_oe_o   = oe_q;
    assign reg_wr_o    = wr_q;
    assign reg_rd_o    = rdp_q;
    assign reg_addr_o  = raddr_q;
    assign reg_wdata_o = wdata_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            mdc_s_q  <= '0;
            mdio_s_q <= '0;
            mdc_p_q  <= 1'b0;
            state_q  <= IDLE;
            pre_q    <= '0;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            rd_q     <= 1'b0;
            sel_q    <= 1'b0;
            adr_q    <= '0;
            sh_q     <= '0;
            oe_q     <= 1'b0;
            dout_q   <= 1'b0;
            wr_q     <= 1'b0;
            rdp_q    <= 1'b0;
            raddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            mdc_s_q  <= {mdc_s_q[0], mdc_i};
            mdio_s_q <= {mdio_s_q[0], mdio_i};
            mdc_p_q  <= mdc_s_q[1];
            state_q  <= state_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            sel_q    <= sel_d;
            adr_q    <= adr_d;
            sh_q     <= sh_d;
            oe_q     <= oe_d;
            dout_q   <= dout_d;
            wr_q     <= wr_d;
            rdp_q    <= rdp_d;
            raddr_q  <= raddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Frame sequencing; the preamble count is only nonzero while in IDLE.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        if (re) begin
            case (state_q)
                IDLE: begin
                    pre_d   = din ? (pre_full ? pre_q : pre_q + 1'b1) : '0;
                    state_d = (!din && pre_full) ? ST : IDLE;
                end
                ST: begin
                    state_d = din ? OP : IDLE;
                    cnt_d   = '0;
                end
                OP: begin
                    op_d    = din;
                    cnt_d   = cnt_q[0] ? 4'd0 : cnt_q + 4'd1;
                    rd_d    = cnt_q[0] ? (op_q & ~din) : rd_q;
                    state_d = cnt_q[0] ? ((op_q ^ din) ? PHYAD : IDLE) : OP;
                end
                PHYAD, REGAD: begin
                    adr_d   = {adr_q[3:0], din};
                    cnt_d   = (cnt_q == 4'd4) ? 4'd0 : cnt_q + 4'd1;
                    sel_d   = (state_q == PHYAD && cnt_q == 4'd4) ? ({adr_q[3:0], din} == phy_addr_i) : sel_q;
                    state_d = (cnt_q != 4'd4) ? state_q : (state_q == PHYAD ? REGAD : TA);
                end
                TA: begin
                    cnt_d   = cnt_q[0] ? 4'd0 : cnt_q + 4'd1;
                    state_d = cnt_q[0] ? DATA : TA;
                end
                DATA: begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = (cnt_q == 4'd15) ? IDLE : DATA;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Registered pad drive, strobes and data shifting.
    always_comb begin
        oe_d    = oe_q;
        dout_d  = dout_q;
        wr_d    = 1'b0;
        rdp_d   = 1'b0;
        raddr_d = raddr_q;
        wdata_d = wdata_q;
        sh_d    = rdp_q ? reg_rdata_i : sh_q;
        if (re) begin
            if (state_q == REGAD && cnt_q == 4'd4 && sel_q && rd_q) begin
                rdp_d   = 1'b1;
                raddr_d = {adr_q[3:0], din};
            end
            if (state_q == TA && sel_q && rd_q) begin
                oe_d   = 1'b1;
                dout_d = cnt_q[0] ? sh_q[15] : 1'b0;
                sh_d   = cnt_q[0] ? {sh_q[14:0], 1'b0} : sh_q;
            end
            if (state_q == DATA && rd_q && sel_q) begin
                oe_d   = cnt_q != 4'd15;
                dout_d = (cnt_q != 4'd15) & sh_q[15];
                sh_d   = {sh_q[14:0], 1'b0};
            end
            if (state_q == DATA && !rd_q) begin
                sh_d = {sh_q[14:0], din};
                if (sel_q && cnt_q == 4'd15) begin
                    wr_d    = 1'b1;
                    raddr_d = adr_q;
                    wdata_d = {sh_q[14:0], din};
                end
            end
        end
    end
endmodule

// File: tb/tb_mdio_slave.sv
// tb_mdio_slave: directed MDIO master frames with immediate-assertion checks.
module tb_mdio_slave;
    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        mdc_i = 1'b0;
    logic        mdio_i = 1'b1;
    logic        mdio_o, mdio_oe_o;
    logic [4:0]  phy_addr_i = 5'h1F;
    logic [4:0]  reg_addr_o;
    logic [15:0] reg_wdata_o;
    logic        reg_wr_o, reg_rd_o;
    logic [15:0] reg_rdata_i = 16'hC3A5;

    int n_asrt = 0, n_fail = 0;
    int wr_n = 0, rd_n = 0, both_n = 0;

    mdio_slave #(.PRE_LEN(32)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .mdc_i(mdc_i), .mdio_i(mdio_i),
        .mdio_o(mdio_o), .mdio_oe_o(mdio_oe_o), .phy_addr_i(phy_addr_i),
        .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
        .reg_wr_o(reg_wr_o), .reg_rd_o(reg_rd_o), .reg_rdata_i(reg_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (reg_wr_o) wr_n++;
        if (reg_rd_o) rd_n++;
        if (reg_wr_o && reg_rd_o) both_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // One MDC period; master samples the pad just before its rising edge.
    task automatic send_bit(input logic b, input logic rst, output logic s_oe, output logic s_d);
        mdio_i = b;
        clks(8);
        s_oe  = mdio_oe_o;
        s_d   = mdio_o;
        mdc_i = 1'b1;
        if (rst) begin
            clks(4);
            chk("oe_before_rst", mdio_oe_o, 1'b1);
            rstn_i = 1'b0;
            clks(1);
            chk("oe_on_rst_edge", mdio_oe_o, 1'b0);
            clks(3);
            mdc_i = 1'b0;
            clks(4);
            rstn_i = 1'b1;
        end else begin
            clks(8);
            mdc_i = 1'b0;
        end
    endtask

    task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rg,
                         input logic [15:0] wd, input int rst_at, output logic [16:0] rbits, output int oe_n);
        logic [31:0] f;
        logic s_oe, s_d;
        f = {2'b01, op, phy, rg, (op == 2'b10) ? 2'b11 : 2'b10, (op == 2'b10) ? 16'hFFFF : wd};
        rbits = '0;
        oe_n  = 0;
        for (int i = 0; i < pre; i++) send_bit(1'b1, 1'b0, s_oe, s_d);
        for (int i = 0; i < 32; i++) begin
            send_bit(f[31-i], (i + 1) == rst_at, s_oe, s_d);
            if (i + 1 >= 16) rbits = {rbits[15:0], s_d};
            oe_n += int'(s_oe);
        end
        clks(4);
    endtask

    initial begin
        logic [16:0] rb;
        int oe_n, w0, r0;
        clks(5);
        chk("rst_oe", mdio_oe_o, 1'b0);
        chk("rst_mdio_o", mdio_o, 1'b0);
        chk("rst_wr", reg_wr_o, 1'b0);
        chk("rst_rd", reg_rd_o, 1'b0);
        chk("rst_addr", reg_addr_o, 5'h00);
        chk("rst_wdata", reg_wdata_o, 16'h0000);
        rstn_i = 1'b1;
        clks(4);

        w0 = wr_n; r0 = rd_n;
        frame(32, 2'b01, 5'h1F, 5'h0E, 16'h5A5A, 0, rb, oe_n);
        chk("wr1_pulses", wr_n - w0, 1);
        chk("wr1_no_rd", rd_n - r0, 0);
        chk("wr1_addr", reg_addr_o, 5'h0E);
        chk("wr1_data", reg_wdata_o, 16'h5A5A);
        chk("wr1_oe_count", oe_n, 0);

        w0 = wr_n; r0 = rd_n;
        frame(32, 2'b10, 5'h1F, 5'h0D, 16'h0000, 0, rb, oe_n);
        chk("rd1_pulses", rd_n - r0, 1);
        chk("rd1_no_wr", wr_n - w0, 0);
        chk("rd1_addr", reg_addr_o, 5'h0D);
        chk("rd1_oe_count", oe_n, 17);
        chk("rd1_bits", rb, 17'h0C3A5);
        chk("rd1_oe_released", mdio_oe_o, 1'b0);
        chk("rd1_wdata_held", reg_wdata_o, 16'h5A5A);

        w0 = wr_n; r0 = rd_n;
        frame(32, 2'b10, 5'h03, 5'h0D, 16'h0000, 0, rb, oe_n);
        chk("unsel_rd_pulses", rd_n - r0, 0);
        chk("unsel_wr_pulses", wr_n - w0, 0);
        chk("unsel_oe_count", oe_n, 0);
        frame(32, 2'b01, 5'h1F, 5'h01, 16'h1234, 0, rb, oe_n);
        chk("after_unsel_wr_pulses", wr_n - w0, 1);
        chk("after_unsel_addr", reg_addr_o, 5'h01);
        chk("after_unsel_data", reg_wdata_o, 16'h1234);

        w0 = wr_n;
        frame(31, 2'b01, 5'h1F, 5'h02, 16'hBEEF, 0, rb, oe_n);
        chk("short_pre_pulses", wr_n - w0, 0);
        chk("short_pre_addr_held", reg_addr_o, 5'h01);
        frame(32, 2'b01, 5'h1F, 5'h02, 16'hBEEF, 0, rb, oe_n);
        chk("full_pre_pulses", wr_n - w0, 1);
        chk("full_pre_addr", reg_addr_o, 5'h02);
        chk("full_pre_data", reg_wdata_o, 16'hBEEF);

        w0 = wr_n; r0 = rd_n;
        frame(32, 2'b11, 5'h1F, 5'h04, 16'hFFFF, 0, rb, oe_n);
        chk("op11_wr_pulses", wr_n - w0, 0);
        chk("op11_rd_pulses", rd_n - r0, 0);
        frame(32, 2'b01, 5'h1F, 5'h03, 16'h0F0F, 0, rb, oe_n);
        chk("after_op11_pulses", wr_n - w0, 1);
        chk("after_op11_addr", reg_addr_o, 5'h03);
        chk("after_op11_data", reg_wdata_o, 16'h0F0F);

        frame(32, 2'b10, 5'h1F, 5'h0D, 16'h0000, 24, rb, oe_n);
        chk("post_rst_addr", reg_addr_o, 5'h00);
        r0 = rd_n;
        reg_rdata_i = 16'h9669;
        frame(0, 2'b10, 5'h1F, 5'h0D, 16'h0000, 0, rb, oe_n);
        chk("no_pre_rd_pulses", rd_n - r0, 0);
        chk("no_pre_oe_count", oe_n, 0);
        frame(32, 2'b10, 5'h1F, 5'h0D, 16'h0000, 0, rb, oe_n);
        chk("rd2_pulses", rd_n - r0, 1);
        chk("rd2_addr", reg_addr_o, 5'h0D);
        chk("rd2_bits", rb, 17'h09669);
        chk("rd2_oe_count", oe_n, 17);

        chk("wr_rd_overlap", both_n, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/mdio_slave.md
MDIO_SLAVE -- requirements
Module: mdio_slave

Interface
REQ-001 SHALL have parameter PRE_LEN, default 32: minimum count of consecutive preamble '1' bits that arms frame detection.
REQ-002 SHALL have port clk_i  input  1  system clock, at least 8x the MDC frequency; only clock domain.
REQ-003 SHALL have port rstn_i  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port mdc_i  input  1  MDC from the pad, asynchronous to clk_i.
REQ-005 SHALL have port mdio_i  input  1  MDIO input from the pad, asynchronous.
REQ-006 SHALL have port mdio_o  output  1  MDIO output data to the pad.
REQ-007 SHALL have port mdio_oe_o  output  1  MDIO pad output enable, 1 = drive.
REQ-008 SHALL have port phy_addr_i  input  5  own PHY address, quasi-static.
REQ-009 SHALL have port reg_addr_o  output  5  register address of the current frame.
REQ-010 SHALL have port reg_wdata_o  output  16  write data.
REQ-011 SHALL have port reg_wr_o  output  1  one-cycle write strobe.
REQ-012 SHALL have port reg_rd_o  output  1  one-cycle read strobe.
REQ-013 SHALL have port reg_rdata_i  input  16  read data, valid the clk_i cycle after reg_rd_o.

Function
REQ-014 SHALL pass mdc_i and mdio_i through identical 2-flop synchronizers; an MDC rising edge (RE) is a 0->1 transition of the synchronized MDC and is a one-cycle event; all bits SHALL be sampled from synchronized mdio_i on RE.
REQ-015 SHALL implement Clause-22 frames with states IDLE, ST, OP, PHYAD, REGAD, TA, DATA, counting bits in RE events only.
REQ-016 In IDLE, SHALL count consecutive sampled '1's, saturating at PRE_LEN; a sampled '0' with count < PRE_LEN SHALL clear the count; a '0' with count == PRE_LEN SHALL be ST bit 1 -> ST.
REQ-017 In ST, sampled '1' -> OP; sampled '0' -> IDLE with count cleared.
REQ-018 In OP, 2 bits MSB-first: 01 = write, 10 = read, 00/11 -> IDLE (abort).
REQ-019 PHYAD (5 bits) and REGAD (5 bits) SHALL be shifted in MSB-first; the frame is "selected" iff PHYAD == phy_addr_i.
REQ-020 On the RE capturing REGAD bit 0 of a selected read, SHALL load reg_addr_o and pulse reg_rd_o for exactly one cycle; SHALL register reg_rdata_i into a 16-bit shift register on the next cycle.
REQ-021 Read TA: on the RE of TA bit 1, SHALL assert mdio_oe_o=1 with mdio_o=0; on each of the next 16 REs, mdio_o SHALL present shift data MSB-first (bit 15 on the 1st RE, bit 0 on the 16th); on the 17th RE, mdio_oe_o SHALL drop to 0 and the FSM SHALL return to IDLE.
REQ-022 Write TA: both TA bits SHALL be ignored; the next 16 bits SHALL be shifted in MSB-first; on the RE capturing bit 0 of a selected write, SHALL load reg_addr_o and reg_wdata_o and pulse reg_wr_o for one cycle.
REQ-023 Unselected frames SHALL traverse all states with mdio_oe_o=0 and no strobes, returning to IDLE after the 16th data bit.
REQ-024 Every return to IDLE SHALL clear the preamble count; each frame requires its own preamble.
REQ-025 reg_addr_o and reg_wdata_o SHALL hold their values between frames; reg_wr_o and reg_rd_o SHALL never assert in the same cycle.
REQ-026 MDC stopping mid-frame SHALL freeze state (no timeout); only reset aborts.

Reset
REQ-027 With rstn_i=0 on a clk_i edge: FSM=IDLE, preamble count=0, mdio_oe_o=0, mdio_o=0, reg_wr_o=0, reg_rd_o=0, reg_addr_o=0, reg_wdata_o=0, shift registers=0, synchronizers=0.
REQ-028 Reset asserted mid-frame SHALL release MDIO (mdio_oe_o=0) on the same clk_i edge and suppress pending strobes; after release, a full preamble SHALL be required.

Verification
REQ-029 phy_addr_i=0x1F; 32x'1', write phy 0x1F reg 0x0E data 0x5A5A -> single reg_wr_o pulse, reg_addr_o=0x0E, reg_wdata_o=0x5A5A, mdio_oe_o never 1.
REQ-030 Read phy 0x1F reg 0x0D, reg_rdata_i=0xC3A5 -> one reg_rd_o pulse, reg_addr_o=0x0D; mdio_oe_o high for exactly 17 MDC periods; master samples 0 then 1100001110100101.
REQ-031 Read phy 0x03 with phy_addr_i=0x1F -> no strobes, mdio_oe_o stays 0; a following valid write is accepted.
REQ-032 31x'1' preamble, then a valid write -> frame ignored, no strobe; the same frame with 32x'1' -> accepted.
REQ-033 OP=11 after valid preamble/ST -> return to IDLE, no strobes; the next valid frame is accepted.
REQ-034 rstn_i=0 during read DATA bit 8 -> mdio_oe_o=0 on that edge; after release, a read without a new preamble is ignored and a read with a full preamble succeeds.
